fifo_rr_arbiter: RTL

Round-robin pop controller that drains four source FIFOs (BUS_SIZE-wide, empty/valid_out interface) into one shared downstream FIFO. It issues one-hot pops to non-empty sources, captures the returned word and pushes it downstream. It honours the downstream FIFO's pause/continua watermark flow control through a hysteresis state machine. It sits between the per-lane FIFO bank and the merged-output FIFO of the switch datapath.

---
 rtl/fifo_rr_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rr_arbiter
// Brief    : Round-robin pop controller. It drains four source FIFOs into one
//            downstream FIFO, with pause/continua hysteresis flow control.
//            Define FIFO_RR_ARB_ERR_EN to add a sticky err output.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rr_arbiter #(
    parameter int BUS_SIZE = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            empty_in,
    input  logic [3:0]            valid_in,
    input  logic [4*BUS_SIZE-1:0] data_in,
    input  logic                  pause_dn,
    input  logic                  continua_dn,
    output logic [3:0]            pop,
    output logic                  push,
    output logic [BUS_SIZE-1:0]   data_out,
    output logic [1:0]            grant_id,
    output logic [1:0]            state
`ifdef FIFO_RR_ARB_ERR_EN
    ,
    output logic                  err
`endif
);

    localparam int c_NUM_SRC = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_last;
    logic                 r_tag_valid;
    logic [1:0]           r_tag_id;
    logic                 r_push;
    logic [BUS_SIZE-1:0]  r_data;
    logic [1:0]           r_grant;

    logic                 w_any_ready;
    logic                 w_cand_found;
    logic [1:0]           w_cand_id;
    logic                 w_pop_en;
    logic                 w_ret_ok;
    logic [BUS_SIZE-1:0]  w_src_data [c_NUM_SRC];

    generate
        for (genvar g = 0; g < c_NUM_SRC; g++) begin : g_unpack
            assign w_src_data[g] = data_in[g*BUS_SIZE +: BUS_SIZE];
        end
    endgenerate

    assign w_any_ready = ~&empty_in;

    // Cyclic search starting one past the last grant; offset 4 wraps back to
    // the last granted port itself, so it is considered last.
    always_comb begin
        w_cand_found = 1'b0;
        w_cand_id    = 2'd0;
        for (int k = 1; k <= c_NUM_SRC; k++) begin
            if (!w_cand_found && !empty_in[r_last + 2'(k)]) begin
                w_cand_found = 1'b1;
                w_cand_id    = r_last + 2'(k);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (pause_dn)
                    w_state_nxt = ST_PAUSE;
                else if (w_any_ready)
                    w_state_nxt = ST_ARB;
            end
            ST_ARB: begin
                if (pause_dn)
                    w_state_nxt = ST_PAUSE;
                else if (!w_any_ready)
                    w_state_nxt = ST_IDLE;
            end
            ST_PAUSE: begin
                if (continua_dn && !pause_dn)
                    w_state_nxt = ST_ARB;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // pause_dn cuts the pop in the same cycle, so only words already tagged
    // can still arrive once the downstream FIFO asks to stop.
    assign w_pop_en = (r_state == ST_ARB) && !pause_dn && w_cand_found && !reset;
    assign pop      = w_pop_en ? (4'b0001 << w_cand_id) : 4'b0000;

    assign w_ret_ok = r_tag_valid && valid_in[r_tag_id];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_last      <= 2'd3;
            r_tag_valid <= 1'b0;
            r_tag_id    <= 2'd0;
            r_push      <= 1'b0;
            r_data      <= '0;
            r_grant     <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_tag_valid <= w_pop_en;
            if (w_pop_en) begin
                r_tag_id <= w_cand_id;
                r_last   <= w_cand_id;
            end
            r_push <= w_ret_ok;
            if (w_ret_ok) begin
                r_data  <= w_src_data[r_tag_id];
                r_grant <= r_tag_id;
            end
        end
    end

    assign push     = r_push;
    assign data_out = r_data;
    assign grant_id = r_grant;
    assign state    = r_state;

`ifdef FIFO_RR_ARB_ERR_EN
    logic [3:0] w_tag_mask;
    logic       w_err_evt;
    logic       r_err;

    // Flags a tagged pop that came back empty, or a valid with no pop behind it.
    assign w_tag_mask = r_tag_valid ? (4'b0001 << r_tag_id) : 4'b0000;
    assign w_err_evt  = (r_tag_valid && !valid_in[r_tag_id]) ||
                        (|(valid_in & ~w_tag_mask));

    always_ff @(posedge clk) begin
        if (reset)
            r_err <= 1'b0;
        else if (w_err_evt)
            r_err <= 1'b1;
    end

    assign err = r_err;
`else
    // Without the error port, a mismatched return produces no push and nothing else.
`endif

endmodule
`default_nettype wire
